// File: rtl/mem_bus_resp.sv
// mem_bus_resp: MAB/MDB memory responder (RAM, program memory, reset vector) with wait states; in clk rst MAB MDB_wr MREQ MW BW, out MDB_out MRDY MERR
module mem_bus_resp #(
  parameter int unsigned RAM_BASE    = 'h0200,
  parameter int unsigned RAM_BYTES   = 1024,
  parameter int unsigned PROG_BASE   = 'hC000,
  parameter logic [15:0] RST_VEC     = 16'hC000,
  parameter int unsigned WAIT_STATES = 0,
  parameter string       INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] MAB,
  input  logic [15:0] MDB_wr,
  input  logic        MREQ,
  input  logic        MW,
  input  logic        BW,
  output logic [15:0] MDB_out,
  output logic        MRDY,
  output logic        MERR
);
  localparam int unsigned RAM_WORDS  = RAM_BYTES / 2;
  localparam int unsigned RAM_AW     = $clog2(RAM_WORDS);
  localparam int unsigned PROG_WORDS = ('hFFFE - PROG_BASE) / 2;
  localparam int unsigned PROG_AW    = $clog2(PROG_WORDS);
  localparam logic [3:0]  WS_LOAD    = WAIT_STATES > 0 ? 4'(WAIT_STATES - 1) : 4'd0;
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;
  state_t state, state_nx;
  logic [3:0] cnt;
  logic [15:0] a_q, d_q, mdb_q, ea, w, rd;
  logic [7:0] wh;
  logic mw_q, bw_q, is_ram, is_prog, is_vec, resp;
  logic [RAM_AW-1:0] ri;
  logic [PROG_AW-1:0] pi;
  logic [15:0] ram [RAM_WORDS];
  logic [15:0] prog [PROG_WORDS];
  always_ff @(posedge clk)
    state <= rst ? S_IDLE : state_nx;
  always_comb
    state_nx = state == S_IDLE ? (MREQ ? (WAIT_STATES > 0 ? S_WAIT : S_RESP) : S_IDLE)
             : state == S_WAIT ? (cnt == 4'd0 ? S_RESP : S_WAIT)
             : S_IDLE;
  always_comb begin
    resp    = state == S_RESP && !rst;
    MRDY    = resp;
    MERR    = resp && !(is_ram || is_prog || is_vec);
    MDB_out = resp && !mw_q ? rd : mdb_q;
  end
  always_comb begin
    ea      = bw_q ? a_q : {a_q[15:1], 1'b0};
    is_vec  = a_q[15:1] == 15'h7FFF;
    is_ram  = 32'(ea) >= RAM_BASE && 32'(ea) < RAM_BASE + RAM_BYTES;
    is_prog = !is_vec && 32'(ea) >= PROG_BASE && ea <= 16'hFFFD;
    ri      = RAM_AW'((32'(ea) - RAM_BASE) >> 1);
    pi      = PROG_AW'((32'(ea) - PROG_BASE) >> 1);
    w       = is_ram ? ram[ri] : is_prog ? prog[pi] : is_vec ? RST_VEC : 16'h0000;
    rd      = bw_q ? {8'h00, ea[0] ? w[15:8] : w[7:0]} : w;
    wh      = bw_q ? d_q[7:0] : d_q[15:8];
  end
  always_ff @(posedge clk)
    if (rst) begin
      cnt   <= 4'd0;
      mdb_q <= 16'h0000;
    end else begin
      if (state == S_IDLE && MREQ) begin
        a_q  <= MAB;
        d_q  <= MDB_wr;
        mw_q <= MW;
        bw_q <= BW;
        cnt  <= WS_LOAD;
      end else if (state == S_WAIT && cnt != 4'd0) cnt <= cnt - 4'd1;
      if (resp && !mw_q) mdb_q <= rd;
    end
  always_ff @(posedge clk)
    if (resp && mw_q) begin
      if (is_ram && (!bw_q || !ea[0])) ram[ri][7:0] <= d_q[7:0];
      if (is_ram && (!bw_q || ea[0])) ram[ri][15:8] <= wh;
      if (is_prog && (!bw_q || !ea[0])) prog[pi][7:0] <= d_q[7:0];
      if (is_prog && (!bw_q || ea[0])) prog[pi][15:8] <= wh;
    end
endmodule
